// File: rtl/bank_scanner_if.sv
// Purpose : bundles the scanner's request, bank-read and result signals into one port.
// Latency : none; this file only carries wires.
// Backpr. : none; start is a level sampled by the scanner only when it is idle.
// Ports   : start (req), addrR/datOutR (bank read), busy/done (status),
//           total/max_val/max_idx/sat (held results).
// The master modport faces the scanner. The slave modport faces the bank and the result consumer.
interface bank_scanner_if #(
  parameter int BIT_ADDR = 4,
  parameter int BIT_DATO = 3
);
  logic                         start;
  logic [BIT_ADDR-1:0]          addrR;
  logic [BIT_DATO-1:0]          datOutR;
  logic                         busy;
  logic                         done;
  logic [BIT_ADDR+BIT_DATO-1:0] total;
  logic [BIT_DATO-1:0]          max_val;
  logic [BIT_ADDR-1:0]          max_idx;
  logic                         sat;

  modport master (
    input  start, datOutR,
    output addrR, busy, done, total, max_val, max_idx, sat
  );

  modport slave (
    output start, datOutR,
    input  addrR, busy, done, total, max_val, max_idx, sat
  );
endinterface

// File: rtl/bank_scanner.sv
// Purpose : sweeps all NREG bank entries and reduces them to total, max value/index and a saturation flag.
// Latency : start accepted at edge N; entry k is sampled at edge N+1+k; done and new results follow edge N+NREG.
// Backpr. : start is ignored while busy, and requests are not queued. Results stay stable until the next done.
// Ports   : clk, rst (async, active-high), bus (bank_scanner_if.master).
// Config  : define BANK_SCAN_AUTO_EN to rescan continuously.
//           In that mode start is ignored and the period is NREG+1 cycles.
module bank_scanner #(
  parameter int BIT_ADDR = 4,
  parameter int BIT_DATO = 3
) (
  input  logic            clk,
  input  logic            rst,
  bank_scanner_if.master  bus
);
  localparam int BIT_SUM = BIT_ADDR + BIT_DATO;
  localparam logic [BIT_ADDR-1:0] ADDR_LAST = '1;
  localparam logic [BIT_DATO-1:0] DAT_FULL  = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state, stateNext;
  logic                busy;
  logic                sweepBegin;
  logic                lastSample;

  logic [BIT_ADDR-1:0] addrR;
  logic [BIT_SUM-1:0]  accSum, sumNext;
  logic [BIT_DATO-1:0] accMax, maxNext;
  logic [BIT_ADDR-1:0] accIdx, idxNext;
  logic                accSat, satNext;

  logic                doneR;
  logic [BIT_SUM-1:0]  totalR;
  logic [BIT_DATO-1:0] maxValR;
  logic [BIT_ADDR-1:0] maxIdxR;
  logic                satR;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and status
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
`ifdef BANK_SCAN_AUTO_EN
        stateNext = SCAN;
`else
        if (bus.start) stateNext = SCAN;
`endif
      end
      SCAN: begin
        busy = 1'b1;
        if (addrR == ADDR_LAST) stateNext = DONE;
      end
      DONE: begin
        busy = 1'b1;
`ifdef BANK_SCAN_AUTO_EN
        stateNext = SCAN;
`else
        stateNext = IDLE;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  assign sweepBegin = (state != SCAN) && (stateNext == SCAN);
  assign lastSample = (state == SCAN) && (addrR == ADDR_LAST);

  // Accumulator values after folding in the current sample.
  // A strict compare keeps the lowest index on ties.
  always_comb begin
    sumNext = accSum + BIT_SUM'(bus.datOutR);
    maxNext = accMax;
    idxNext = accIdx;
    if (bus.datOutR > accMax) begin
      maxNext = bus.datOutR;
      idxNext = addrR;
    end
    satNext = accSat | (bus.datOutR == DAT_FULL);
  end

  // Sweep datapath.
  // The results are loaded on the edge that takes the last sample, so done and the new values appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrR   <= '0;
      accSum  <= '0;
      accMax  <= '0;
      accIdx  <= '0;
      accSat  <= 1'b0;
      doneR   <= 1'b0;
      totalR  <= '0;
      maxValR <= '0;
      maxIdxR <= '0;
      satR    <= 1'b0;
    end else begin
      if (sweepBegin) begin
        addrR  <= '0;
        accSum <= '0;
        accMax <= '0;
        accIdx <= '0;
        accSat <= 1'b0;
      end else if (state == SCAN) begin
        // The address naturally wraps to 0 after the last entry.
        addrR  <= addrR + BIT_ADDR'(1);
        accSum <= sumNext;
        accMax <= maxNext;
        accIdx <= idxNext;
        accSat <= satNext;
      end
      doneR <= lastSample;
      if (lastSample) begin
        totalR  <= sumNext;
        maxValR <= maxNext;
        maxIdxR <= idxNext;
        satR    <= satNext;
      end
    end
  end

  assign bus.addrR   = addrR;
  assign bus.busy    = busy;
  assign bus.done    = doneR;
  assign bus.total   = totalR;
  assign bus.max_val = maxValR;
  assign bus.max_idx = maxIdxR;
  assign bus.sat     = satR;
endmodule

// File: tb/tb_bank_scanner.sv
// Purpose : checks bank_scanner against a whole-array reference model.
//           Covers directed banks, random banks, hazards and reset.
// Latency : inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Backpr. : the bank is a combinational array indexed by addrR; start is driven directly.
module tb_bank_scanner;
  localparam int BIT_ADDR = 4;
  localparam int BIT_DATO = 3;
  localparam int NREG     = 2**BIT_ADDR;
  localparam int FULL     = 2**BIT_DATO - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_scanner_if #(.BIT_ADDR(BIT_ADDR), .BIT_DATO(BIT_DATO)) bus();
  bank_scanner #(.BIT_ADDR(BIT_ADDR), .BIT_DATO(BIT_DATO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [BIT_DATO-1:0] bank [NREG];
  assign bus.datOutR = bank[bus.addrR];

  int nChecks = 0;
  int nBad    = 0;

  // Expected results from the reference model, and the values expected to be held until the next done.
  int expSum, expMax, expIdx, expSat;
  int prevSum = 0, prevMax = 0, prevIdx = 0, prevSat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Reference model computed over the whole array:
  // the sum, the largest value, the first index holding it, and saturation (some entry at full scale).
  task automatic model();
    expSum = 0;
    expMax = 0;
    for (int i = 0; i < NREG; i++) begin
      expSum += int'(bank[i]);
      if (int'(bank[i]) > expMax) expMax = int'(bank[i]);
    end
    expIdx = -1;
    for (int i = 0; i < NREG; i++)
      if (expIdx < 0 && int'(bank[i]) == expMax) expIdx = i;
    expSat = (expMax == FULL) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearBank();
    for (int i = 0; i < NREG; i++) bank[i] = '0;
  endtask

  task automatic checkResults(input string tag);
    check({tag, "_total"}, bus.total, expSum);
    check({tag, "_max_val"}, bus.max_val, expMax);
    check({tag, "_max_idx"}, bus.max_idx, expIdx);
    check({tag, "_sat"}, bus.sat, expSat);
  endtask

  // Waits for the next done pulse within a cycle budget. Returns the number of edges waited, or 0 on timeout.
  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    for (int c = 1; c <= 3 * NREG && cycles == 0; c++) begin
      tick();
      if (bus.done === 1'b1) cycles = c;
    end
    if (cycles == 0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_addrR"}, bus.addrR, 0);
    check({tag, "_total"}, bus.total, 0);
    check({tag, "_max_val"}, bus.max_val, 0);
    check({tag, "_max_idx"}, bus.max_idx, 0);
    check({tag, "_sat"}, bus.sat, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

`ifndef BANK_SCAN_AUTO_EN
  // One start-triggered sweep. Optionally checks the address walk, and optionally pokes start at cycle 5 to confirm it is ignored.
  task automatic runSweep(input string tag, input bit checkWalk, input bit pokeStart);
    int lat;
    int extra;
    model();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_addr0"}, bus.addrR, 0);
    lat = 0;
    for (int c = 1; c <= NREG + 4 && lat == 0; c++) begin
      bus.start = (pokeStart && c == 5);
      tick();
      if (bus.done === 1'b1) lat = c;
      else begin
        if (checkWalk) check({tag, "_walk"}, bus.addrR, c);
        if (c == NREG / 2) check({tag, "_hold"}, bus.total, prevSum);
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, lat, NREG);
    check({tag, "_addrWrap"}, bus.addrR, 0);
    checkResults(tag);
    prevSum = expSum; prevMax = expMax; prevIdx = expIdx; prevSat = expSat;
    tick();
    check({tag, "_donePulse"}, bus.done, 0);
    check({tag, "_idle"}, bus.busy, 0);
    if (pokeStart) begin
      extra = 0;
      for (int c = 0; c < NREG + 4; c++) begin
        tick();
        if (bus.done === 1'b1) extra++;
      end
      check({tag, "_noRequeue"}, extra, 0);
    end
  endtask
`endif

  initial begin
    int cyc;
    int cnt;
    bus.start = 1'b0;
    clearBank();
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    rst = 1'b0;

`ifndef BANK_SCAN_AUTO_EN
    tick();
    tick();
    runSweep("zero", 1'b1, 1'b0);

    bank[3] = 3'd5; bank[9] = 3'd2;
    runSweep("two", 1'b1, 1'b0);

    clearBank();
    bank[2] = 3'd4; bank[11] = 3'd4;
    runSweep("tie", 1'b0, 1'b0);

    for (int i = 0; i < NREG; i++) bank[i] = 3'd1;
    bank[15] = 3'd7;
    runSweep("satLast", 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREG; i++)
        bank[i] = BIT_DATO'((r % 2 == 0) ? $urandom_range(0, 6) : $urandom_range(0, 7));
      runSweep("rand", 1'b0, 1'b0);
    end

    for (int i = 0; i < NREG; i++) bank[i] = BIT_DATO'($urandom_range(1, 6));
    runSweep("poke", 1'b0, 1'b1);

    // Reset asserted mid-sweep, 8 cycles after start is accepted
    clearBank();
    bank[4] = 3'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    checkReset("midRst");
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < NREG + 4; c++) begin
      tick();
      if (bus.done === 1'b1) cnt++;
    end
    check("midRst_noDone", cnt, 0);
    check("midRst_idle", bus.busy, 0);

    // Start held high gives back-to-back sweeps with one idle cycle between them
    for (int i = 0; i < NREG; i++) bank[i] = BIT_DATO'($urandom_range(0, 7));
    model();
    bus.start = 1'b1;
    waitDone("b2b_first", cyc);
    waitDone("b2b_second", cyc);
    bus.start = 1'b0;
    check("b2b_period", cyc, NREG + 2);
    checkResults("b2b");
    tick();
    tick();
    check("b2b_idle", bus.busy, 0);
`else
    // Continuous rescanning: done every NREG+1 cycles with no start
    waitDone("auto_first", cyc);
    waitDone("auto_period1", cyc);
    check("auto_period1", cyc, NREG + 1);
    waitDone("auto_period2", cyc);
    check("auto_period2", cyc, NREG + 1);
    model();
    checkResults("auto_zero");
    bank[0] = 3'd6;
    model();
    waitDone("auto_chg1", cyc);
    waitDone("auto_chg2", cyc);
    checkResults("auto_chg");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++) bank[i] = BIT_DATO'($urandom_range(0, 7));
      model();
      waitDone("auto_rand1", cyc);
      waitDone("auto_rand2", cyc);
      checkResults("auto_rand");
    end
`endif

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
